// File: rtl/prio_enc_tsg_if.sv
// Request/grant handshake bundle between request sources and the priority encoder.
// The encoder (slave) arbitrates req and answers with valid/grant until ack.
interface prio_enc_tsg_if #(
    parameter int N = 8
);
    logic [N-1:0] req;
    logic         mode;
    logic         en;
    logic         ack;
    logic         valid;
    logic [N-1:0] grant;

    modport master (
        output req, mode, en, ack,
        input  valid, grant
    );

    modport slave (
        input  req, mode, en, ack,
        output valid, grant
    );
endinterface

// File: rtl/prio_enc_tsg.sv
// Registered fixed/round-robin priority encoder; winner visible 1 cycle after req, held until ack.
// No new grant while one is held (peak one grant per 2 cycles); code_bus floats unless en && valid.
module prio_enc_tsg #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    prio_enc_tsg_if.slave bus,
    output wire  [W-1:0]  code_bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]   r_state;
    logic [W-1:0] r_code;
    logic [N-1:0] r_grant;
    logic [W-1:0] r_ptr;
    logic         r_rr;

    logic [W-1:0]   w_fp_idx;
    logic [2*N-1:0] w_req2;
    logic [N-1:0]   w_rot;
    logic [W-1:0]   w_off;
    logic [W:0]     w_sum;
    logic [W-1:0]   w_rr_idx;
    logic [W-1:0]   w_win;
    logic [N-1:0]   w_onehot;
    logic [W-1:0]   w_ptr_nxt;

    // Fixed priority: the last set bit in ascending order is the highest index.
    always_comb begin
        w_fp_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.req[i]) w_fp_idx = W'(i);
        end
    end

    // Round-robin: rotate req so the pointer sits at bit 0, take the lowest set bit,
    // then add the pointer back modulo N (works for non-power-of-two N).
    assign w_req2 = {bus.req, bus.req};
    assign w_rot  = N'(w_req2 >> r_ptr);

    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = W'(k);
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (W+1)'(N)) begin
            w_rr_idx = W'(w_sum - (W+1)'(N));
        end else begin
            w_rr_idx = w_sum[W-1:0];
        end
    end

    assign w_win     = bus.mode ? w_rr_idx : w_fp_idx;
    assign w_onehot  = {{(N-1){1'b0}}, 1'b1} << w_win;
    assign w_ptr_nxt = (r_code == W'(N - 1)) ? '0 : r_code + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_code  <= '0;
            r_grant <= '0;
            r_ptr   <= '0;
            r_rr    <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (bus.req != '0) begin
                r_state <= S_HOLD;
                r_code  <= w_win;
                r_grant <= w_onehot;
                r_rr    <= bus.mode;
            end
        end else begin
            // The pointer only advances past winners chosen by round-robin.
            if (bus.ack) begin
                r_state <= S_IDLE;
                r_grant <= '0;
                if (r_rr) r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign bus.valid = (r_state == S_HOLD);
    assign bus.grant = r_grant;
    assign code_bus  = (bus.en && (r_state == S_HOLD)) ? r_code : {W{1'bz}};
endmodule
